rca_seq_adder: RTL and testbench

//  Multi-cycle add/subtract unit. Processes a WIDTH-bit operand pair in CHUNK-bit slices,
//  one slice per clock, through a single CHUNK-bit ripple-carry slice.
//  The carry is registered between slices, trading latency for area.

---
 rtl/rca_pkg.sv | 24 ++
 rtl/rca_fulladder.sv | 20 ++
 rtl/rca_slice.sv | 32 +++
 rtl/rca_seq_adder.sv | 154 +++++++++++++++
 tb/tb_rca_seq_adder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rca_pkg.sv
// Shared types and sizing helpers for the multi-cycle ripple-carry add/sub unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rca_pkg;

  // Control FSM states of the sequential adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of CHUNK-bit slices needed to cover a WIDTH-bit operand.
  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Width of the slice index counter; never narrower than one bit so the
  // single-slice configuration still has a legal counter.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage : rca_pkg

// File: rtl/rca_fulladder.sv
// One-bit full adder, the basic cell of the ripple chain.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: a, b, c_in -> s (sum bit), c_out (carry to the next bit).
module rca_fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ c_in;
  // Generate when both bits are set, propagate an incoming carry otherwise.
  assign c_out    = (a & b) | (c_in & half_sum);

endmodule : rca_fulladder

// File: rtl/rca_slice.sv
// CHUNK-bit ripple-carry adder built from a chain of full adders.
// Latency: combinational (CHUNK full-adder delays on the carry path).
// Backpressure: none (pure logic).
// Ports: a, b (CHUNK-bit slices), c_in (carry into bit 0) -> s, c_out (carry out of MSB).
module rca_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out
);

  // c[i] is the carry into bit i; c[CHUNK] leaves the slice.
  logic [CHUNK:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    rca_fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (c[i]),
      .s    (s[i]),
      .c_out(c[i+1])
    );
  end

  assign c_out = c[CHUNK];

endmodule : rca_slice

// File: rtl/rca_seq_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit ripple slice reused LSB-first, carry registered between slices.
// Latency: out_valid rises WIDTH/CHUNK edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; a new operand pair may be accepted on the draining edge.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake; a, b, sub captured on accept
//   out_valid/out_ready      result handshake; s, c_out, ovf valid while out_valid
module rca_seq_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IW     = calc_idx_w(NCHUNK);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("rca_seq_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // already inverted for subtraction
  logic            carry_q;
  logic            sign_a_q;
  logic            sign_b_q;   // sign of the effective (possibly inverted) B
  logic [WIDTH-1:0] s_q;
  logic            c_out_q;
  logic            ovf_q;
  logic            out_valid_q;

  logic             accept;
  logic [WIDTH-1:0] b_eff;
  int               base_idx;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] sum_d;
  logic             carry_d;

  // Ready depends only on state and the consumer, never on in_valid, so the
  // handshake cannot form a combinational loop with the producer.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
  assign b_eff = sub ? ~b : b;

  // Select the slice currently being processed.
  always_comb begin
    base_idx = int'(idx_q) * CHUNK;
    a_slice  = a_q[base_idx +: CHUNK];
    b_slice  = b_q[base_idx +: CHUNK];
  end

  rca_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a    (a_slice),
    .b    (b_slice),
    .c_in (carry_q),
    .s    (sum_d),
    .c_out(carry_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      s_q         <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q      <= a;
            b_q      <= b_eff;
            carry_q  <= sub;
            sign_a_q <= a[WIDTH-1];
            sign_b_q <= b_eff[WIDTH-1];
            idx_q    <= '0;
            state_q  <= RUN;
          end
        end

        RUN: begin
          s_q[base_idx +: CHUNK] <= sum_d;
          carry_q                <= carry_d;
          if (idx_q == LAST_IDX) begin
            // The last slice holds the result MSB, so the flags are final here.
            c_out_q     <= carry_d;
            ovf_q       <= (sign_a_q == sign_b_q) && (sum_d[CHUNK-1] != sign_a_q);
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              // Drain and refill on the same edge: no idle bubble.
              a_q      <= a;
              b_q      <= b_eff;
              carry_q  <= sub;
              sign_a_q <= a[WIDTH-1];
              sign_b_q <= b_eff[WIDTH-1];
              idx_q    <= '0;
              state_q  <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule : rca_seq_adder

// File: tb/tb_rca_seq_adder.sv
// Scoreboard bench for rca_seq_adder: lane 0 is 16/4 (directed), lane 1 is 16/16, lane 2 is 12/3 (random).
// Latency: each lane's expected latency is its slice count (4, 1, 4).
// Backpressure: lane 0 exercises out_ready stalls and same-edge drain/refill.
module tb_rca_seq_adder;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  in_valid_l, in_ready_l, sub_l, out_valid_l, out_ready_l, c_l, o_l;
  logic [15:0] a_l [3];
  logic [15:0] b_l [3];
  logic [15:0] s_l [3];
  logic [11:0] s12;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t pend [3];
  exp_t fifo [3][8];
  int   wp [3] = '{0, 0, 0};
  int   rp [3] = '{0, 0, 0};
  logic [2:0] lat_done = 3'b000;

  rca_seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_l[0]), .in_ready(in_ready_l[0]),
    .a(a_l[0]), .b(b_l[0]), .sub(sub_l[0]), .out_valid(out_valid_l[0]),
    .out_ready(out_ready_l[0]), .s(s_l[0]), .c_out(c_l[0]), .ovf(o_l[0])
  );

  rca_seq_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_l[1]), .in_ready(in_ready_l[1]),
    .a(a_l[1]), .b(b_l[1]), .sub(sub_l[1]), .out_valid(out_valid_l[1]),
    .out_ready(out_ready_l[1]), .s(s_l[1]), .c_out(c_l[1]), .ovf(o_l[1])
  );

  rca_seq_adder #(.WIDTH(12), .CHUNK(3)) u_dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid_l[2]), .in_ready(in_ready_l[2]),
    .a(a_l[2][11:0]), .b(b_l[2][11:0]), .sub(sub_l[2]), .out_valid(out_valid_l[2]),
    .out_ready(out_ready_l[2]), .s(s12), .c_out(c_l[2]), .ovf(o_l[2])
  );

  assign s_l[2] = {4'h0, s12};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int l);
    return (l == 1) ? 1 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model in plain integer arithmetic: unsigned range for the carry,
  // signed range for overflow.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic sb,
                       output logic [15:0] es, output logic ec, output logic eo);
    int m, ua, ub, sa, sbv, r, sr;
    m   = (1 << w) - 1;
    ua  = int'(a) & m;
    ub  = int'(b) & m;
    sa  = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sbv = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    r   = sb ? ua - ub : ua + ub;
    sr  = sb ? sa - sbv : sa + sbv;
    es  = 16'(r & m);
    ec  = sb ? (ua >= ub) : (r > m);
    eo  = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
  endtask

  // Present an operand pair and hold it until the accepting edge has passed.
  task automatic send(input int l, input logic [15:0] a, input logic [15:0] b, input logic sb,
                      input logic [15:0] es, input logic ec, input logic eo);
    int   n;
    logic ok;
    a_l[l]      = a;
    b_l[l]      = b;
    sub_l[l]    = sb;
    pend[l].s   = es;
    pend[l].c   = ec;
    pend[l].o   = eo;
    pend[l].acc = 0;
    in_valid_l[l] = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready_l[l];
      n++;
    end
    if (!ok) chk($sformatf("accept_timeout_l%0d", l), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid_l[l] = 1'b0;
  endtask

  task automatic wait_drain(input int l);
    int n;
    n = 0;
    while (rp[l] != wp[l] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rp[l] != wp[l]) chk($sformatf("drain_timeout_l%0d", l), 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int l);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid_l[l] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_l[l]) chk($sformatf("valid_timeout_l%0d", l), 32'd0, 32'd1);
  endtask

  task automatic run_rand(input int l, input int w);
    logic [15:0] m, ra, rb, es;
    logic        rs, ec, eo;
    m = 16'((32'd1 << w) - 1);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom) & m;
      rb = 16'($urandom) & m;
      rs = 1'($urandom);
      model(w, ra, rb, rs, es, ec, eo);
      send(l, ra, rb, rs, es, ec, eo);
    end
  endtask

  // Stimulus side: record the expectation at the moment an accept is seen.
  always @(negedge clk) begin
    if (!rst) begin
      for (int l = 0; l < 3; l++) begin
        if (in_valid_l[l] && in_ready_l[l]) begin
          exp_t e;
          e     = pend[l];
          e.acc = cyc + 1;
          fifo[l][wp[l] % 8] = e;
          wp[l]++;
        end
      end
    end
  end

  // Monitor: compare every cycle the DUT presents a result; pop on handshake.
  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (rst) begin
        rp[l]       = wp[l];
        lat_done[l] = 1'b0;
      end else if (out_valid_l[l]) begin
        if (rp[l] == wp[l]) begin
          chk($sformatf("unexpected_result_l%0d", l), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = fifo[l][rp[l] % 8];
          if (!lat_done[l]) begin
            chk($sformatf("latency_l%0d", l), 32'(cyc - e.acc), 32'(lat_of(l)));
            lat_done[l] = 1'b1;
          end
          chk($sformatf("sum_l%0d", l), 32'(s_l[l]), 32'(e.s));
          chk($sformatf("c_out_l%0d", l), 32'(c_l[l]), 32'(e.c));
          chk($sformatf("ovf_l%0d", l), 32'(o_l[l]), 32'(e.o));
          chk($sformatf("in_ready_done_l%0d", l), 32'(in_ready_l[l]), 32'(out_ready_l[l]));
          if (out_ready_l[l]) begin
            rp[l]++;
            lat_done[l] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    in_valid_l  = '0;
    sub_l       = '0;
    out_ready_l = '1;
    for (int l = 0; l < 3; l++) begin
      a_l[l] = '0;
      b_l[l] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid_l[0]), 32'd0);
    chk("rst_s", 32'(s_l[0]), 32'd0);
    chk("rst_c_out", 32'(c_l[0]), 32'd0);
    chk("rst_ovf", 32'(o_l[0]), 32'd0);
    chk("rst_in_ready", 32'(in_ready_l[0]), 32'd1);
    @(posedge clk);
    #1;

    // Signed overflow on add; unit busy while running
    send(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    @(negedge clk);
    chk("run_in_ready", 32'(in_ready_l[0]), 32'd0);
    wait_drain(0);

    // Subtraction with and without borrow
    send(0, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    wait_drain(0);

    // Stall in DONE for 3 cycles; the monitor re-checks stability each cycle
    out_ready_l[0] = 1'b0;
    send(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_valid(0);
    repeat (3) @(posedge clk);
    #1;
    out_ready_l[0] = 1'b1;
    wait_drain(0);

    // Drain and refill on the same edge
    out_ready_l[0] = 1'b0;
    send(0, 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);
    wait_valid(0);
    @(posedge clk);
    #1;
    out_ready_l[0] = 1'b1;
    send(0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_running", 32'(out_valid_l[0]), 32'd0);
    wait_drain(0);

    // Reset on the second RUN edge discards the operation
    send(0, 16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid_l[0]), 32'd0);
    chk("abort_s", 32'(s_l[0]), 32'd0);
    chk("abort_in_ready", 32'(in_ready_l[0]), 32'd1);
    @(posedge clk);
    #1;
    send(0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    wait_drain(0);

    // Single-cycle and 12-bit configurations against the integer model
    fork
      run_rand(1, 16);
      run_rand(2, 12);
    join
    wait_drain(1);
    wait_drain(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rca_seq_adder
